// File: rtl/alu_mul_sequencer_if.sv
// ---------------------------------------------------------------------------
// alu_mul_sequencer_if
//   Bundles every non-clock/reset signal of the multiply sequencer: the
//   multiply request/response pair, the core decode's ALU request and
//   controls, and the ALU-facing control/result lines.
//
//   slave  modport : seen by alu_mul_sequencer
//   master modport : seen by whoever drives the sequencer (core + ALU side)
//
//   Signals
//     start, op_a, op_b          multiply request and operands
//     busy, done, result         multiply status and product (mod 256)
//     core_*                     core decode ALU request/controls
//     core_stall                 core ALU request must wait
//     alu_in1/in2/op/...         controls driven into the shared ALU
//     alu_out_val                ALU combinational result
//
//   The ALU op 01 ("andb") is expected to gate in1 with bit 0 of in2
//   (in1 & {8{in2[0]}}), which is what makes ANDB produce a partial product.
// ---------------------------------------------------------------------------
interface alu_mul_sequencer_if;
    logic       start;
    logic [7:0] op_a;
    logic [7:0] op_b;
    logic       busy;
    logic       done;
    logic [7:0] result;

    logic       core_alu_req;
    logic [7:0] core_in1;
    logic [7:0] core_in2;
    logic [1:0] core_alu_op;
    logic [1:0] core_branch_sel;
    logic       core_sub;
    logic       core_branch;
    logic       core_shift_left;
    logic       core_stall;

    logic [7:0] alu_in1;
    logic [7:0] alu_in2;
    logic [1:0] alu_op;
    logic [1:0] alu_branch_sel;
    logic       alu_sub;
    logic       alu_branch;
    logic       alu_shift_left;
    logic [7:0] alu_out_val;

    modport slave (
        input  start, op_a, op_b,
        input  core_alu_req, core_in1, core_in2, core_alu_op, core_branch_sel,
        input  core_sub, core_branch, core_shift_left,
        input  alu_out_val,
        output busy, done, result, core_stall,
        output alu_in1, alu_in2, alu_op, alu_branch_sel,
        output alu_sub, alu_branch, alu_shift_left
    );

    modport master (
        output start, op_a, op_b,
        output core_alu_req, core_in1, core_in2, core_alu_op, core_branch_sel,
        output core_sub, core_branch, core_shift_left,
        output alu_out_val,
        input  busy, done, result, core_stall,
        input  alu_in1, alu_in2, alu_op, alu_branch_sel,
        input  alu_sub, alu_branch, alu_shift_left
    );
endinterface

// File: rtl/alu_mul_sequencer.sv
// ---------------------------------------------------------------------------
// alu_mul_sequencer
//   Owns the control inputs of the shared 8-bit ALU. While idle the core
//   decode's ALU controls pass straight through. On an accepted start it
//   takes the ALU over and runs an unsigned shift-and-add multiply using
//   the ALU itself (ANDB / ADD / SHL / SHR per multiplier bit), stalling
//   core ALU requests until the DONE cycle.
//
//   Parameters
//     WIDTH      datapath width (must be 8, the ALU width)
//     EARLY_EXIT 1: stop once the remaining multiplier is zero
//
//   Ports
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    alu_mul_sequencer_if.slave (request, core and ALU signals)
// ---------------------------------------------------------------------------
module alu_mul_sequencer #(
    parameter int WIDTH      = 8,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    alu_mul_sequencer_if.slave    bus
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ANDB = 3'd1,
        S_ADD  = 3'd2,
        S_SHL  = 3'd3,
        S_SHR  = 3'd4,
        S_DONE = 3'd5
    } state_t;

    state_t             state_q,  state_d;
    logic [7:0]         acc_q,    acc_d;
    logic [7:0]         mcand_q,  mcand_d;
    logic [7:0]         mplier_q, mplier_d;
    logic [7:0]         pp_q,     pp_d;
    logic [CNT_W-1:0]   cnt_q,    cnt_d;
    logic [7:0]         result_q, result_d;

    // The sequencer owns the ALU only in the four working states.
    logic takeover;
    assign takeover = (state_q == S_ANDB) || (state_q == S_ADD) ||
                      (state_q == S_SHL)  || (state_q == S_SHR);

    assign bus.busy       = (state_q != S_IDLE);
    assign bus.done       = (state_q == S_DONE);
    assign bus.result     = result_q;
    assign bus.core_stall = bus.core_alu_req && takeover;

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        pp_d     = pp_q;
        cnt_d    = cnt_q;
        result_d = result_q;

        // Pass-through is the default; working states override below.
        bus.alu_in1        = bus.core_in1;
        bus.alu_in2        = bus.core_in2;
        bus.alu_op         = bus.core_alu_op;
        bus.alu_branch_sel = bus.core_branch_sel;
        bus.alu_sub        = bus.core_sub;
        bus.alu_branch     = bus.core_branch;
        bus.alu_shift_left = bus.core_shift_left;

        if (takeover) begin
            bus.alu_branch_sel = 2'b00;
            bus.alu_branch     = 1'b0;
            bus.alu_sub        = 1'b0;
            bus.alu_shift_left = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    mcand_d  = bus.op_a;
                    mplier_d = bus.op_b;
                    acc_d    = '0;
                    cnt_d    = '0;
                    if (EARLY_EXIT && (bus.op_b == 8'd0)) begin
                        // Entering DONE straight away: the accumulator is
                        // being cleared, so the product is zero.
                        state_d  = S_DONE;
                        result_d = '0;
                    end else begin
                        state_d = S_ANDB;
                    end
                end
            end
            S_ANDB: begin
                // Partial product: multiplicand gated by multiplier LSB.
                bus.alu_in1 = mcand_q;
                bus.alu_in2 = mplier_q;
                bus.alu_op  = 2'b01;
                pp_d        = bus.alu_out_val;
                state_d     = S_ADD;
            end
            S_ADD: begin
                bus.alu_in1 = acc_q;
                bus.alu_in2 = pp_q;
                bus.alu_op  = 2'b00;
                acc_d       = bus.alu_out_val;
                state_d     = S_SHL;
            end
            S_SHL: begin
                bus.alu_in1        = mcand_q;
                bus.alu_in2        = 8'd1;
                bus.alu_op         = 2'b11;
                bus.alu_shift_left = 1'b1;
                mcand_d            = bus.alu_out_val;
                state_d            = S_SHR;
            end
            S_SHR: begin
                bus.alu_in1 = mplier_q;
                bus.alu_in2 = 8'd1;
                bus.alu_op  = 2'b11;
                mplier_d    = bus.alu_out_val;
                cnt_d       = cnt_q + CNT_W'(1);
                // cnt_q is the pre-increment iteration index here.
                if ((cnt_q == CNT_W'(WIDTH - 1)) ||
                    (EARLY_EXIT && (bus.alu_out_val == 8'd0))) begin
                    state_d  = S_DONE;
                    result_d = acc_q;
                end else begin
                    state_d = S_ANDB;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            pp_q     <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            pp_q     <= pp_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alu_mul_sequencer
//   Drives the sequencer through a table of multiply vectors, a reset-abort
//   sequence and a batch of random operands. A behavioural ALU closes the
//   loop on alu_out_val. Expected products, latencies and per-cycle ALU
//   usage are derived from plain arithmetic on the operands.
// ---------------------------------------------------------------------------
module tb_alu_mul_sequencer;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    alu_mul_sequencer_if bus ();

    alu_mul_sequencer #(
        .WIDTH      (8),
        .EARLY_EXIT (1'b1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Behavioural shared ALU.
    logic [7:0] alu_res;
    always_comb begin
        alu_res = 8'd0;
        case (bus.alu_op)
            2'b00: alu_res = bus.alu_sub ? (bus.alu_in1 - bus.alu_in2)
                                         : (bus.alu_in1 + bus.alu_in2);
            2'b01: alu_res = bus.alu_in1 & {8{bus.alu_in2[0]}};
            2'b10: alu_res = bus.alu_in1 ^ bus.alu_in2;
            default: alu_res = bus.alu_shift_left ? (bus.alu_in1 << bus.alu_in2[2:0])
                                                  : (bus.alu_in1 >> bus.alu_in2[2:0]);
        endcase
    end
    assign bus.alu_out_val = alu_res;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] exp_res;
        int         exp_lat;
        bit         hold_req;
        int         restart_cyc;   // cycle at which a stray start(2,2) is pulsed; 0 = none
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_core(input bit hold);
        bus.core_alu_req    = hold ? 1'b1 : 1'($urandom_range(0, 1));
        bus.core_in1        = 8'($urandom);
        bus.core_in2        = 8'($urandom);
        bus.core_alu_op     = 2'($urandom);
        bus.core_branch_sel = 2'($urandom);
        bus.core_sub        = 1'($urandom);
        bus.core_branch     = 1'($urandom);
        bus.core_shift_left = 1'($urandom);
    endtask

    task automatic check_pass(input string name);
        check(name,
              {7'd0, bus.alu_in1, bus.alu_in2, bus.alu_op, bus.alu_branch_sel,
               bus.alu_sub, bus.alu_branch, bus.alu_shift_left},
              {7'd0, bus.core_in1, bus.core_in2, bus.core_alu_op, bus.core_branch_sel,
               bus.core_sub, bus.core_branch, bus.core_shift_left});
    endtask

    // Reference latency: 4 cycles per multiplier bit up to the top set bit, plus 1.
    function automatic int ref_latency(input logic [7:0] b);
        int n = 0;
        for (int i = 0; i < 8; i++) if (b[i]) n = i + 1;
        return 4 * n + 1;
    endfunction

    function automatic logic [7:0] ref_product(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = 16'(a) * 16'(b);
        return p[7:0];
    endfunction

    // Issue one multiply at the next cycle and check it cycle by cycle.
    task automatic run_mult(input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] exp_res, input int exp_lat,
                            input bit hold, input int restart_cyc);
        int         it, ph, seen_lat;
        logic [7:0] mc, mp, accv, ppv, bl;
        seen_lat = -1;

        @(negedge clk);
        bus.start = 1'b1;
        bus.op_a  = a;
        bus.op_b  = b;
        drive_core(hold);
        #1;
        check("accept_busy", {31'd0, bus.busy}, 32'd0);
        check("accept_stall", {31'd0, bus.core_stall}, 32'd0);
        check_pass("accept_pass");

        for (int k = 1; k <= exp_lat + 1; k++) begin
            @(negedge clk);
            if (k == restart_cyc) begin
                bus.start = 1'b1;
                bus.op_a  = 8'd2;
                bus.op_b  = 8'd2;
            end else begin
                bus.start = 1'b0;
                bus.op_a  = 8'($urandom);
                bus.op_b  = 8'($urandom);
            end
            drive_core(hold);
            #1;
            if (bus.done && seen_lat < 0) seen_lat = k;
            if (k < exp_lat) begin
                it   = (k - 1) / 4;
                ph   = (k - 1) % 4;
                mc   = a << it;
                mp   = b >> it;
                bl   = b & 8'((1 << it) - 1);
                accv = a * bl;
                ppv  = b[it] ? mc : 8'd0;
                check("seq_busy", {30'd0, bus.busy, bus.done}, 32'd2);
                check("seq_stall", {31'd0, bus.core_stall}, {31'd0, bus.core_alu_req});
                check("seq_ctl", {29'd0, bus.alu_branch_sel, bus.alu_branch}, 32'd0);
                case (ph)
                    0: begin
                        check("andb_op",  {30'd0, bus.alu_op}, 32'd1);
                        check("andb_in1", {24'd0, bus.alu_in1}, {24'd0, mc});
                        check("andb_in2", {24'd0, bus.alu_in2}, {24'd0, mp});
                    end
                    1: begin
                        check("add_op",  {29'd0, bus.alu_op, bus.alu_sub}, 32'd0);
                        check("add_in1", {24'd0, bus.alu_in1}, {24'd0, accv});
                        check("add_in2", {24'd0, bus.alu_in2}, {24'd0, ppv});
                    end
                    2: begin
                        check("shl_op",  {29'd0, bus.alu_op, bus.alu_shift_left}, 32'd7);
                        check("shl_in",  {16'd0, bus.alu_in1, bus.alu_in2}, {16'd0, mc, 8'd1});
                    end
                    default: begin
                        check("shr_op",  {29'd0, bus.alu_op, bus.alu_shift_left}, 32'd6);
                        check("shr_in",  {16'd0, bus.alu_in1, bus.alu_in2}, {16'd0, mp, 8'd1});
                    end
                endcase
            end else if (k == exp_lat) begin
                check("done_flags", {30'd0, bus.busy, bus.done}, 32'd3);
                check("done_result", {24'd0, bus.result}, {24'd0, exp_res});
                check("done_stall", {31'd0, bus.core_stall}, 32'd0);
                check_pass("done_pass");
            end else begin
                check("after_flags", {30'd0, bus.busy, bus.done}, 32'd0);
                check("after_result", {24'd0, bus.result}, {24'd0, exp_res});
                check("after_stall", {31'd0, bus.core_stall}, 32'd0);
                check_pass("after_pass");
            end
        end
        bus.start = 1'b0;
        $display("txn a=0x%02h b=0x%02h result=0x%02h latency=%0d (expected 0x%02h, %0d)",
                 a, b, bus.result, seen_lat, exp_res, exp_lat);
    endtask

    initial begin
        int done_seen;
        logic [7:0] ra, rb;

        vecs[0] = '{8'd13,  8'd11,  8'h8F, 17, 1'b1, 0};
        vecs[1] = '{8'd13,  8'd11,  8'h8F, 17, 1'b1, 6};
        vecs[2] = '{8'd2,   8'd2,   8'h04, 9,  1'b0, 0};
        vecs[3] = '{8'd200, 8'd3,   8'h58, 9,  1'b0, 0};
        vecs[4] = '{8'd255, 8'd255, 8'h01, 33, 1'b0, 0};
        vecs[5] = '{8'hAA,  8'd0,   8'h00, 1,  1'b1, 0};
        vecs[6] = '{8'd7,   8'd1,   8'h07, 5,  1'b0, 5};
        vecs[7] = '{8'd1,   8'd128, 8'h80, 33, 1'b0, 0};

        bus.start = 1'b0;
        bus.op_a  = 8'd0;
        bus.op_b  = 8'd0;
        drive_core(1'b1);
        rst_n = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check("reset_flags", {29'd0, bus.busy, bus.done, bus.core_stall}, 32'd0);
        check("reset_result", {24'd0, bus.result}, 32'd0);
        check_pass("reset_pass");
        @(negedge clk);
        rst_n = 1'b1;

        for (int v = 0; v < 8; v++) begin
            run_mult(vecs[v].a, vecs[v].b, vecs[v].exp_res, vecs[v].exp_lat,
                     vecs[v].hold_req, vecs[v].restart_cyc);
        end

        // Reset abort in the middle of 255x255.
        @(negedge clk);
        bus.start = 1'b1;
        bus.op_a  = 8'd255;
        bus.op_b  = 8'd255;
        drive_core(1'b1);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            bus.start = 1'b0;
            drive_core(1'b1);
            if (k == 6) rst_n = 1'b0;
            #1;
            if (k < 6) check("abort_run_busy", {31'd0, bus.busy}, 32'd1);
        end
        check("abort_flags", {29'd0, bus.busy, bus.done, bus.core_stall}, 32'd0);
        check("abort_result", {24'd0, bus.result}, 32'd0);
        check_pass("abort_pass");
        done_seen = 0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            #1;
            if (bus.done) done_seen++;
        end
        rst_n = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            #1;
            if (bus.done || bus.busy) done_seen++;
        end
        check("abort_no_done", done_seen, 32'd0);
        $display("txn reset abort of 255x255: result=0x%02h", bus.result);
        run_mult(8'd3, 8'd5, 8'h0F, 13, 1'b0, 0);

        // Random operands against the arithmetic reference.
        for (int r = 0; r < 20; r++) begin
            ra = 8'($urandom);
            rb = (r % 5 == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'($urandom);
            run_mult(ra, rb, ref_product(ra, rb), ref_latency(rb),
                     1'($urandom_range(0, 1)), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
